// File: rtl/v_id_sb.sv
// v_id_sb: vector decode stage with a valid/ready slot towards EX and a RAW/WAW destination scoreboard.
// Optional V_ID_STALL_CNT_EN adds stall_cnt_o, a saturating count of hazard-stalled offer cycles.
module v_id_sb #(
    parameter int SEW       = 32,
    parameter int VALUOP_DW = 5,
    parameter int VMEM_DW   = 256,
    parameter int VMEM_AW   = 32,
    parameter int VREG_DW   = 256,
    parameter int VREG_AW   = 5,
    parameter int INST_DW   = 32,
    parameter int REG_DW    = 32,
    parameter int REG_AW    = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inst_valid_i,
    input  logic [INST_DW-1:0]   inst_i,
    output logic                 inst_ready_o,
    output logic                 rs1_en_o,
    output logic [REG_AW-1:0]    rs1_addr_o,
    input  logic [REG_DW-1:0]    rs1_dout_i,
    output logic                 vs1_en_o,
    output logic [VREG_AW-1:0]   vs1_addr_o,
    input  logic [VREG_DW-1:0]   vs1_dout_i,
    output logic                 vs2_en_o,
    output logic [VREG_AW-1:0]   vs2_addr_o,
    input  logic [VREG_DW-1:0]   vs2_dout_i,
    output logic                 id_valid_o,
    input  logic                 ex_ready_i,
    output logic [VALUOP_DW-1:0] valu_opcode_o,
    output logic [VREG_DW-1:0]   operand_v1_o,
    output logic [VREG_DW-1:0]   operand_v2_o,
    output logic                 vmem_ren_o,
    output logic                 vmem_wen_o,
    output logic [VMEM_AW-1:0]   vmem_addr_o,
    output logic [VMEM_DW-1:0]   vmem_din_o,
    output logic                 vid_wb_en_o,
    output logic                 vid_wb_sel_o,
    output logic [VREG_AW-1:0]   vid_wb_addr_o,
    input  logic                 wb_done_en_i,
    input  logic [VREG_AW-1:0]   wb_done_addr_i
`ifdef V_ID_STALL_CNT_EN
    ,
    output logic [31:0]          stall_cnt_o
`endif
);
    localparam int NELEM = VREG_DW / SEW;
    localparam logic [6:0] OPCODE_OP_V     = 7'b1010111;
    localparam logic [6:0] OPCODE_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OPCODE_STORE_FP = 7'b0100111;
    localparam logic [2:0] FUNCT3_OPIVV = 3'b000;
    localparam logic [2:0] FUNCT3_OPIVI = 3'b011;
    localparam logic [2:0] FUNCT3_OPIVX = 3'b100;
    localparam logic [5:0] FUNCT6_VADD  = 6'b000000;
    localparam logic [5:0] FUNCT6_VSUB  = 6'b000010;
    localparam logic [5:0] FUNCT6_VMUL  = 6'b100101;
    localparam logic [VALUOP_DW-1:0] ALU_NOP  = VALUOP_DW'(0);
    localparam logic [VALUOP_DW-1:0] ALU_VADD = VALUOP_DW'(1);
    localparam logic [VALUOP_DW-1:0] ALU_VMUL = VALUOP_DW'(2);
    localparam logic [VALUOP_DW-1:0] ALU_VSUB = VALUOP_DW'(3);

    typedef struct packed {
        logic                 valid;
        logic [VALUOP_DW-1:0] opc;
        logic [VREG_DW-1:0]   v1;
        logic [VREG_DW-1:0]   v2;
        logic                 ren;
        logic                 wen;
        logic [VMEM_AW-1:0]   addr;
        logic [VMEM_DW-1:0]   din;
        logic                 wb_en;
        logic                 wb_sel;
        logic [VREG_AW-1:0]   wb_addr;
    } bundle_t;

    bundle_t bundle_q, bundle_d;
    logic [2**VREG_AW-1:0] sb_q, sb_d;

    logic [6:0] op;
    logic [2:0] f3;
    logic [5:0] f6;
    logic [VREG_AW-1:0] vd, vs1, vs2;
    logic [REG_AW-1:0] rs1;
    logic [SEW-1:0] imm_e, x_e;
    logic [VALUOP_DW-1:0] alu_op;
    logic is_arith, is_vv, is_vi, is_vx, is_ld, is_st, wb_en, rd_en, hazard, fire;
    logic [VREG_DW-1:0] v1, v2;
    logic unused_vm;

    assign op        = inst_i[6:0];
    assign vd        = VREG_AW'(inst_i[11:7]);
    assign f3        = inst_i[14:12];
    assign vs1       = VREG_AW'(inst_i[19:15]);
    assign rs1       = REG_AW'(inst_i[19:15]);
    assign vs2       = VREG_AW'(inst_i[24:20]);
    assign f6        = inst_i[31:26];
    assign unused_vm = inst_i[25];
    // Signed casts both truncate (SEW <= REG_DW) and sign-extend (SEW > REG_DW).
    assign imm_e     = SEW'($signed(inst_i[19:15]));
    assign x_e       = SEW'($signed(rs1_dout_i));

    always_comb begin
        alu_op   = f6 == FUNCT6_VADD ? ALU_VADD : f6 == FUNCT6_VMUL ? ALU_VMUL : f6 == FUNCT6_VSUB ? ALU_VSUB : ALU_NOP;
        is_arith = op == OPCODE_OP_V && alu_op != ALU_NOP &&
                   (f3 == FUNCT3_OPIVV || f3 == FUNCT3_OPIVX || (f3 == FUNCT3_OPIVI && alu_op != ALU_VSUB));
        is_vv    = is_arith && f3 == FUNCT3_OPIVV;
        is_vi    = is_arith && f3 == FUNCT3_OPIVI;
        is_vx    = is_arith && f3 == FUNCT3_OPIVX;
        is_ld    = op == OPCODE_LOAD_FP;
        is_st    = op == OPCODE_STORE_FP;
        wb_en    = is_arith | is_ld;
        rd_en    = inst_valid_i & ~rst;
        rs1_en_o   = rd_en & (is_vx | is_ld | is_st);
        rs1_addr_o = rs1_en_o ? rs1 : '0;
        vs1_en_o   = rd_en & is_vv;
        vs1_addr_o = vs1_en_o ? vs1 : '0;
        vs2_en_o   = rd_en & (is_arith | is_st);
        vs2_addr_o = !vs2_en_o ? '0 : is_st ? vd : vs2;
        v1 = is_vv ? vs1_dout_i : is_vi ? {NELEM{imm_e}} : is_vx ? {NELEM{x_e}} : '0;
        v2 = vs2_en_o ? vs2_dout_i : '0;
        hazard = inst_valid_i & ((is_vv & sb_q[vs1]) | (is_arith & sb_q[vs2]) | ((is_st | wb_en) & sb_q[vd]));
        inst_ready_o = ~rst & ~hazard & (~bundle_q.valid | ex_ready_i);
        fire = inst_valid_i & inst_ready_o;
    end

    always_comb begin
        bundle_d = bundle_q;
        sb_d     = sb_q;
        if (fire) begin
            bundle_d.valid   = 1'b1;
            bundle_d.opc     = is_arith ? alu_op : ALU_NOP;
            bundle_d.v1      = v1;
            bundle_d.v2      = v2;
            bundle_d.ren     = is_ld;
            bundle_d.wen     = is_st;
            bundle_d.addr    = (is_ld | is_st) ? VMEM_AW'(rs1_dout_i) : '0;
            bundle_d.din     = is_st ? VMEM_DW'(vs2_dout_i) : '0;
            bundle_d.wb_en   = wb_en;
            bundle_d.wb_sel  = is_ld;
            bundle_d.wb_addr = wb_en ? vd : '0;
        end else if (ex_ready_i) begin
            bundle_d.valid = 1'b0;
        end
        // Clear first so a same-cycle set of the same entry wins.
        if (wb_done_en_i) sb_d[wb_done_addr_i] = 1'b0;
        if (fire && wb_en) sb_d[vd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        bundle_q <= rst ? '0 : bundle_d;
        sb_q     <= rst ? '0 : sb_d;
    end

    assign id_valid_o    = bundle_q.valid;
    assign valu_opcode_o = bundle_q.opc;
    assign operand_v1_o  = bundle_q.v1;
    assign operand_v2_o  = bundle_q.v2;
    assign vmem_ren_o    = bundle_q.ren;
    assign vmem_wen_o    = bundle_q.wen;
    assign vmem_addr_o   = bundle_q.addr;
    assign vmem_din_o    = bundle_q.din;
    assign vid_wb_en_o   = bundle_q.wb_en;
    assign vid_wb_sel_o  = bundle_q.wb_sel;
    assign vid_wb_addr_o = bundle_q.wb_addr;

`ifdef V_ID_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    always_comb begin
        stall_cnt_d = (inst_valid_i & hazard & ~rst & ~&stall_cnt_q) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end
    always_ff @(posedge clk) begin
        stall_cnt_q <= rst ? 32'd0 : stall_cnt_d;
    end
    assign stall_cnt_o = stall_cnt_q;
`endif
endmodule

// File: tb/tb_v_id_sb.sv
// tb_v_id_sb: randomized and directed stimulus for v_id_sb (SEW=32 and SEW=16 instances) against a behavioural model.
module tb_v_id_sb;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, inst_valid_i, ex_ready_i, wb_done_en_i;
    logic [31:0] inst_i;
    logic [4:0] wb_done_addr_i;

    logic [31:0] xrf [32];
    logic [255:0] vrf [32];

    logic inst_ready_o, rs1_en_o, vs1_en_o, vs2_en_o, id_valid_o, vmem_ren_o, vmem_wen_o, vid_wb_en_o, vid_wb_sel_o;
    logic [4:0] rs1_addr_o, vs1_addr_o, vs2_addr_o, vid_wb_addr_o, valu_opcode_o;
    logic [31:0] rs1_dout_i, vmem_addr_o;
    logic [255:0] vs1_dout_i, vs2_dout_i, operand_v1_o, operand_v2_o, vmem_din_o;
`ifdef V_ID_STALL_CNT_EN
    logic [31:0] stall_cnt_o, h_stall_cnt_o;
`endif

    logic h_ready, h_rs1_en, h_vs1_en, h_vs2_en, h_valid, h_ren, h_wen, h_wb_en, h_wb_sel;
    logic [4:0] h_rs1_addr, h_vs1_addr, h_vs2_addr, h_wb_addr, h_opc;
    logic [31:0] h_rs1_dout, h_addr;
    logic [255:0] h_vs1_dout, h_vs2_dout, h_v1, h_v2, h_din;

    assign rs1_dout_i = xrf[rs1_addr_o];
    assign vs1_dout_i = vrf[vs1_addr_o];
    assign vs2_dout_i = vrf[vs2_addr_o];
    assign h_rs1_dout = xrf[h_rs1_addr];
    assign h_vs1_dout = vrf[h_vs1_addr];
    assign h_vs2_dout = vrf[h_vs2_addr];

    v_id_sb dut (
        .clk(clk), .rst(rst), .inst_valid_i(inst_valid_i), .inst_i(inst_i), .inst_ready_o(inst_ready_o),
        .rs1_en_o(rs1_en_o), .rs1_addr_o(rs1_addr_o), .rs1_dout_i(rs1_dout_i),
        .vs1_en_o(vs1_en_o), .vs1_addr_o(vs1_addr_o), .vs1_dout_i(vs1_dout_i),
        .vs2_en_o(vs2_en_o), .vs2_addr_o(vs2_addr_o), .vs2_dout_i(vs2_dout_i),
        .id_valid_o(id_valid_o), .ex_ready_i(ex_ready_i), .valu_opcode_o(valu_opcode_o),
        .operand_v1_o(operand_v1_o), .operand_v2_o(operand_v2_o), .vmem_ren_o(vmem_ren_o), .vmem_wen_o(vmem_wen_o),
        .vmem_addr_o(vmem_addr_o), .vmem_din_o(vmem_din_o), .vid_wb_en_o(vid_wb_en_o), .vid_wb_sel_o(vid_wb_sel_o),
        .vid_wb_addr_o(vid_wb_addr_o), .wb_done_en_i(wb_done_en_i), .wb_done_addr_i(wb_done_addr_i)
`ifdef V_ID_STALL_CNT_EN
        , .stall_cnt_o(stall_cnt_o)
`endif
    );

    v_id_sb #(.SEW(16)) dut_h (
        .clk(clk), .rst(rst), .inst_valid_i(inst_valid_i), .inst_i(inst_i), .inst_ready_o(h_ready),
        .rs1_en_o(h_rs1_en), .rs1_addr_o(h_rs1_addr), .rs1_dout_i(h_rs1_dout),
        .vs1_en_o(h_vs1_en), .vs1_addr_o(h_vs1_addr), .vs1_dout_i(h_vs1_dout),
        .vs2_en_o(h_vs2_en), .vs2_addr_o(h_vs2_addr), .vs2_dout_i(h_vs2_dout),
        .id_valid_o(h_valid), .ex_ready_i(ex_ready_i), .valu_opcode_o(h_opc),
        .operand_v1_o(h_v1), .operand_v2_o(h_v2), .vmem_ren_o(h_ren), .vmem_wen_o(h_wen),
        .vmem_addr_o(h_addr), .vmem_din_o(h_din), .vid_wb_en_o(h_wb_en), .vid_wb_sel_o(h_wb_sel),
        .vid_wb_addr_o(h_wb_addr), .wb_done_en_i(wb_done_en_i), .wb_done_addr_i(wb_done_addr_i)
`ifdef V_ID_STALL_CNT_EN
        , .stall_cnt_o(h_stall_cnt_o)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Model state: the slot contents EX should see, the in-flight destination set and the stall count.
    logic m_valid, m_ren, m_wen, m_wben, m_wbsel;
    logic [4:0] m_op, m_wbaddr;
    logic [31:0] m_addr, m_stall;
    logic [255:0] m_v1, m_v1h, m_v2, m_din;
    logic [31:0] m_sb;

    function automatic logic [255:0] bcast(input logic [31:0] e, input int sew);
        logic [255:0] r;
        for (int i = 0; i < 256; i++) r[i] = e[i % sew];
        return r;
    endfunction

    function automatic logic [31:0] arith(input logic [5:0] f6, input logic [2:0] f3, input logic [4:0] vd,
                                          input logic [4:0] a, input logic [4:0] b);
        return {f6, 1'b1, b, a, f3, vd, 7'h57};
    endfunction

    task automatic step(input logic v, input logic [31:0] ins, input logic er, input logic de,
                        input logic [4:0] da, input logic r);
        logic [4:0] vd, a, b, aop;
        logic ar, vv, vi, vx, ld, st, wb, haz, rdy, fire, en;
        logic [31:0] imm;
        inst_valid_i = v; inst_i = ins; ex_ready_i = er; wb_done_en_i = de; wb_done_addr_i = da; rst = r;
        vd = ins[11:7]; a = ins[19:15]; b = ins[24:20];
        imm = 32'($signed(ins[19:15]));
        aop = ins[31:26] == 6'b000000 ? 5'd1 : ins[31:26] == 6'b100101 ? 5'd2 : ins[31:26] == 6'b000010 ? 5'd3 : 5'd0;
        ar = ins[6:0] == 7'h57 && aop != 0 &&
             (ins[14:12] == 3'd0 || ins[14:12] == 3'd4 || (ins[14:12] == 3'd3 && aop != 5'd3));
        vv = ar && ins[14:12] == 3'd0;
        vi = ar && ins[14:12] == 3'd3;
        vx = ar && ins[14:12] == 3'd4;
        ld = ins[6:0] == 7'h07;
        st = ins[6:0] == 7'h27;
        wb = ar || ld;
        haz = v && ((vv && m_sb[a]) || (ar && m_sb[b]) || ((st || wb) && m_sb[vd]));
        rdy = !r && !haz && (!m_valid || er);
        fire = v && rdy;
        en = v && !r;
        @(negedge clk);
        check("inst_ready", inst_ready_o, rdy);
        check("inst_ready16", h_ready, rdy);
        check("rs1_en", rs1_en_o, en && (vx || ld || st));
        check("rs1_addr", rs1_addr_o, (en && (vx || ld || st)) ? a : 5'd0);
        check("vs1_en", vs1_en_o, en && vv);
        check("vs1_addr", vs1_addr_o, (en && vv) ? a : 5'd0);
        check("vs2_en", vs2_en_o, en && (ar || st));
        check("vs2_addr", vs2_addr_o, (en && ar) ? b : (en && st) ? vd : 5'd0);
        @(posedge clk);
        #1;
        if (r) begin
            m_valid = 0; m_op = 0; m_v1 = 0; m_v1h = 0; m_v2 = 0; m_ren = 0; m_wen = 0;
            m_addr = 0; m_din = 0; m_wben = 0; m_wbsel = 0; m_wbaddr = 0; m_sb = 0; m_stall = 0;
        end else begin
            if (haz && m_stall != 32'hFFFFFFFF) m_stall++;
            if (fire) begin
                m_valid = 1;
                m_op = ar ? aop : 5'd0;
                m_v1 = vv ? vrf[a] : vi ? bcast(imm, 32) : vx ? bcast(xrf[a], 32) : '0;
                m_v1h = vv ? vrf[a] : vi ? bcast(imm, 16) : vx ? bcast(xrf[a], 16) : '0;
                m_v2 = ar ? vrf[b] : st ? vrf[vd] : '0;
                m_ren = ld; m_wen = st;
                m_addr = (ld || st) ? xrf[a] : 32'd0;
                m_din = st ? vrf[vd] : '0;
                m_wben = wb; m_wbsel = ld; m_wbaddr = wb ? vd : 5'd0;
            end else if (er) begin
                m_valid = 0;
            end
            if (de) m_sb[da] = 1'b0;
            if (fire && wb) m_sb[vd] = 1'b1;
        end
        check("id_valid", id_valid_o, m_valid);
        check("id_valid16", h_valid, m_valid);
`ifdef V_ID_STALL_CNT_EN
        check("stall_cnt", stall_cnt_o, m_stall);
`endif
        if (m_valid || r) begin
            check("opcode", valu_opcode_o, m_op);
            check("v1", operand_v1_o, m_v1);
            check("v2", operand_v2_o, m_v2);
            check("v1_sew16", h_v1, m_v1h);
            check("v2_sew16", h_v2, m_v2);
            check("ren", vmem_ren_o, m_ren);
            check("wen", vmem_wen_o, m_wen);
            check("maddr", vmem_addr_o, m_addr);
            check("mdin", vmem_din_o, m_din);
            check("wb_en", vid_wb_en_o, m_wben);
            check("wb_sel", vid_wb_sel_o, m_wbsel);
            check("wb_addr", vid_wb_addr_o, m_wbaddr);
        end
    endtask

    function automatic logic [4:0] rreg();
        return ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
    endfunction

    function automatic logic [31:0] rinst();
        logic [5:0] f6s [4];
        logic [2:0] f3s [4];
        int k;
        f6s = '{6'b000000, 6'b000010, 6'b100101, 6'b000111};
        f3s = '{3'd0, 3'd3, 3'd4, 3'd1};
        k = $urandom_range(0, 9);
        if (k < 6) return arith(f6s[$urandom_range(0, 2)], f3s[$urandom_range(0, 2)], rreg(), rreg(), rreg());
        if (k == 6) return {7'h01, 5'd0, rreg(), 3'b110, rreg(), 7'h07};
        if (k == 7) return {7'h01, 5'd0, rreg(), 3'b110, rreg(), 7'h27};
        if (k == 8) return arith(f6s[$urandom_range(0, 3)], f3s[$urandom_range(0, 3)], rreg(), rreg(), rreg());
        return {$urandom_range(0, 32'h1FFFFFF), 7'h33};
    endfunction

    initial begin
        logic [31:0] vadd_v3, vsub_v6, st_v5;
        for (int i = 0; i < 32; i++) begin
            xrf[i] = $urandom;
            vrf[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        end
        vrf[1] = {8{32'h1}};
        vrf[2] = {8{32'h2}};
        rst = 1; inst_valid_i = 0; inst_i = 0; ex_ready_i = 0; wb_done_en_i = 0; wb_done_addr_i = 0;
        @(posedge clk);
        #1;
        vadd_v3 = arith(6'b000000, 3'd0, 5'd3, 5'd1, 5'd2);
        vsub_v6 = arith(6'b000010, 3'd0, 5'd6, 5'd1, 5'd3);
        st_v5 = {7'h01, 5'd0, 5'd4, 3'b110, 5'd5, 7'h27};
        step(1, vadd_v3, 1, 0, 0, 1);
        step(1, vadd_v3, 1, 0, 0, 1);
        step(1, vadd_v3, 1, 0, 0, 0);
        check("vadd_opcode", valu_opcode_o, 5'd1);
        check("vadd_v1", operand_v1_o, {8{32'h1}});
        check("vadd_v2", operand_v2_o, {8{32'h2}});
        check("vadd_wb_addr", vid_wb_addr_o, 5'd3);
        step(1, vsub_v6, 1, 0, 0, 0);
        step(1, vsub_v6, 1, 0, 0, 0);
        step(1, vsub_v6, 1, 1, 3, 0);
        step(1, vsub_v6, 1, 0, 0, 0);
        check("vsub_after_clear", valu_opcode_o, 5'd3);
        step(1, arith(6'b100101, 3'd3, 5'd4, 5'b11101, 5'd5), 1, 0, 0, 0);
        check("vmul_vi_sew32", operand_v1_o, {8{32'hFFFFFFFD}});
        check("vmul_vi_sew16", h_v1, {16{16'hFFFD}});
        step(1, st_v5, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, arith(6'b000000, 3'd0, 5'd8, 5'd1, 5'd2), 0, 0, 0, 0);
        step(1, arith(6'b000000, 3'd0, 5'd8, 5'd1, 5'd2), 1, 0, 0, 0);
        step(1, {7'h01, 5'd0, 5'd2, 3'b110, 5'd7, 7'h07}, 1, 1, 7, 0);
        step(1, {7'h01, 5'd0, 5'd2, 3'b110, 5'd7, 7'h07}, 1, 1, 7, 0);
        step(1, {7'h01, 5'd0, 5'd2, 3'b110, 5'd7, 7'h27}, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(1, arith(6'b000010, 3'd3, 5'd9, 5'd3, 5'd1), 1, 0, 0, 0);
        check("vsub_vi_nop_wb", vid_wb_en_o, 1'b0);
        step(1, arith(6'b000000, 3'd0, 5'd31, 5'd1, 5'd2), 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, arith(6'b000000, 3'd0, 5'd10, 5'd1, 5'd31), 1, 0, 0, 0);
`ifdef V_ID_STALL_CNT_EN
        check("stall_cnt_5", stall_cnt_o, 32'd5);
`endif
        step(1, arith(6'b000000, 3'd0, 5'd10, 5'd1, 5'd31), 1, 1, 31, 0);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 3) != 0, rinst(), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) == 0, rreg(), $urandom_range(0, 199) == 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
